// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// ------------------
// Stimulus driver and response monitor for a small combinational lab gate.
// A start request sweeps every input vector to the gate in ascending order.
// Each vector is held for SETTLE_CYC cycles and then sampled for one cycle
// against the TRUTH table. The checker counts mismatches and reports pass/fail.
//
// Parameters:
//   N_IN       number of gate inputs (1..4)
//   TRUTH      expected gate output; bit i applies when dut_in == i
//   SETTLE_CYC cycles dut_in is held before the sample cycle (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; aborts a sweep without done
//   start      begins a sweep; honoured only in IDLE
//   dut_in     vector driven to the gate (MSB = first gate input)
//   dut_out    gate output under test
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse at the end of a sweep
//   pass       1 when the last sweep had zero mismatches
//   err_cnt    mismatch count of the current/last sweep
//   state_dbg  current FSM state (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//
// Optional feature (macro GATE_SWEEP_FIRST_FAIL_EN):
//   fail_seen  a mismatch occurred in this sweep
//   fail_vec   dut_in of the first mismatch
//   fail_got   dut_out observed at the first mismatch
//
// Handshake: start is a level request. It is accepted on a rising clock edge
// when the FSM is in IDLE and rst is low. At any other time it is ignored and
// not queued. done carries no backpressure.
module gate_sweep_checker #(
  parameter int                     N_IN       = 2,
  parameter logic [(2**N_IN)-1:0]   TRUTH      = 4'b1110,
  parameter int                     SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  output logic            fail_seen,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_got,
`endif
  output logic [1:0]      state_dbg
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             mismatch;

  // Case inequality so that an X/Z from the gate counts as a mismatch in
  // simulation. Synthesis treats it as an ordinary inequality.
  assign mismatch  = (dut_out !== TRUTH[dut_in]);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      fail_seen  <= 1'b0;
      fail_vec   <= '0;
      fail_got   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            dut_in     <= '0;
            err_cnt    <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            fail_seen  <= 1'b0;
            fail_vec   <= '0;
            fail_got   <= 1'b0;
`endif
          end
        end

        SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_vec  <= dut_in;
              fail_got  <= dut_out;
            end
`endif
          end
          // The last vector ends the sweep without incrementing dut_in, so
          // dut_in never wraps and keeps its final value in IDLE.
          if (dut_in == {N_IN{1'b1}}) begin
            state <= DONE;
          end else begin
            dut_in     <= dut_in + 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end

        DONE: begin
          // err_cnt already includes the final sample, taken on the
          // previous edge.
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking stimulus driver and response monitor for small combinational lab gates (default: 2-input OR).
- On `start`, drives every input vector to the DUT in ascending order and waits a fixed settle time per vector.
- Samples the DUT output and compares it against a parameterised truth table.
- Reports error count and pass/fail.
- Sits opposite the gate under test: it drives the gate's inputs and reads its output, on-board or in a top-level lab harness.

Parameters:
N_IN, 2, number of DUT inputs (1..4).
TRUTH, 4'b1110, expected output; bit i is the expected dut_out when dut_in == i; width 2**N_IN. Default encodes OR.
SETTLE_CYC, 2, cycles dut_in is held before sampling (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; honoured only in IDLE.
dut_in  output  N_IN  vector driven to the gate under test; MSB = first gate input (a).
dut_out  input  1  gate under test output (c).
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse at end of sweep.
pass  output  1  1 if the last sweep had zero mismatches; held until the next start or rst.
err_cnt  output  N_IN+1  mismatches in the current/last sweep; saturation is not needed (max 2**N_IN).

Behaviour:
- Reset: state IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, settle counter=0. Reset mid-sweep aborts immediately with the same values; no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE.
  - Also on that transition: dut_in<=0, err_cnt<=0, pass<=0, busy<=1, settle counter<=0.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYC-1 -> SAMPLE.
  - dut_in is stable throughout.
- SAMPLE (one cycle):
  - Compare dut_out with TRUTH[dut_in].
  - Mismatch -> err_cnt+1. X/Z on dut_out counts as a mismatch in simulation (case inequality).
  - If dut_in == all ones -> DONE.
  - Otherwise dut_in<=dut_in+1, counter<=0, -> SETTLE.
- DONE (one cycle):
  - done=1, busy=0.
  - pass<=(err_cnt==0), using the final count including the last sample.
  - -> IDLE.
- Latency: done is high exactly 1 + 2**N_IN*(SETTLE_CYC+1) cycles after the clock edge that accepts start. Default: 13.
- Each vector is held SETTLE_CYC+1 cycles; dut_in never wraps within a sweep.
- start while busy or in DONE is ignored.
- start in the cycle after done (state IDLE) is accepted normally.
- start and rst in the same cycle: rst wins.
- err_cnt and dut_in hold their final values in IDLE until the next start.
- All outputs are registered; no combinational path from dut_out to any output.

Optional Feature:
Macro: GATE_SWEEP_FIRST_FAIL_EN
- Defined:
  - Adds outputs fail_seen (1), fail_vec (N_IN) and fail_got (1), all reset to 0 and cleared on accepted start.
  - On the first mismatch of a sweep, fail_seen<=1, fail_vec<=dut_in, fail_got<=dut_out.
  - Later mismatches do not update them.
  - They hold until the next start or rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Correct OR model, defaults, start pulse -> dut_in 0,1,2,3 each held 3 cycles; done at cycle 13; pass=1, err_cnt=0, busy low same cycle as done.
2. Gate stuck-at-0 -> err_cnt=3, pass=0; with GATE_SWEEP_FIRST_FAIL_EN: fail_seen=1, fail_vec=2'b01, fail_got=0.
3. AND model against default TRUTH -> mismatches at vectors 1 and 2; err_cnt=2, pass=0; fail_vec=2'b01.
4. start pulsed again at cycle 5 mid-sweep -> ignored; done still at cycle 13, single done pulse, err_cnt unaffected.
5. rst asserted while dut_in=2'b10 -> next cycle dut_in=0, busy=0, err_cnt=0, pass=0, no done; a new start then completes a full 13-cycle sweep.
6. start held high continuously with a correct OR model -> sweeps back-to-back; start re-accepted in the IDLE cycle after each done; err_cnt cleared each time; pass=1 after each done.
